// File: rtl/forward_hazard_unit_if.sv
// Interface bundling the pipeline-register fields consumed by forward_hazard_unit
// and the operand selects / stall controls it drives back.
// master: pipeline side (drives addresses and control bits).
// slave:  the hazard unit itself.
interface forward_hazard_unit_if #(
    parameter int unsigned ADDR_W = 5
);
    logic [ADDR_W-1:0] id_rs_addr_i;
    logic [ADDR_W-1:0] id_rt_addr_i;
    logic [ADDR_W-1:0] ex_rs_addr_i;
    logic [ADDR_W-1:0] ex_rt_addr_i;
    logic [ADDR_W-1:0] ex_rd_addr_i;
    logic              ex_memread_i;
    logic              ex_mul_i;
    logic [ADDR_W-1:0] mem_rd_addr_i;
    logic              mem_regwrite_i;
    logic [ADDR_W-1:0] wb_rd_addr_i;
    logic              wb_regwrite_i;
    logic [1:0]        select1_o;
    logic [1:0]        select2_o;
    logic              pc_write_o;
    logic              if_id_write_o;
    logic              bubble_o;
    logic              mul_busy_o;

    modport master (
        output id_rs_addr_i, id_rt_addr_i, ex_rs_addr_i, ex_rt_addr_i, ex_rd_addr_i,
        output ex_memread_i, ex_mul_i, mem_rd_addr_i, mem_regwrite_i,
        output wb_rd_addr_i, wb_regwrite_i,
        input  select1_o, select2_o, pc_write_o, if_id_write_o, bubble_o, mul_busy_o
    );

    modport slave (
        input  id_rs_addr_i, id_rt_addr_i, ex_rs_addr_i, ex_rt_addr_i, ex_rd_addr_i,
        input  ex_memread_i, ex_mul_i, mem_rd_addr_i, mem_regwrite_i,
        input  wb_rd_addr_i, wb_regwrite_i,
        output select1_o, select2_o, pc_write_o, if_id_write_o, bubble_o, mul_busy_o
    );
endinterface

// File: rtl/forward_hazard_unit.sv
// EX-stage forwarding and hazard unit.
// - Operand selects: 00 regfile, 01 MEM/WB, 10 EX/MEM, 11 WB history.
// - Load-use detection inserts one bubble and freezes PC / IF/ID.
// - Multi-cycle multiply freezes the front end for MUL_LAT-1 cycles.
// Optional feature macro: FWD_WB_HIST_EN (one-deep WB history register, select 11).
module forward_hazard_unit #(
    parameter int unsigned ADDR_W  = 5,
    parameter int unsigned MUL_LAT = 3,
    parameter int unsigned CNT_W   = 4
) (
    input logic                  clk_i,
    input logic                  rst_i,
    forward_hazard_unit_if.slave bus
);
    typedef enum logic {StIdle, StBusy} state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              load_use;
    logic              pc_write;
    logic              bubble;
    logic [1:0]        sel1, sel2;
    logic              hist_valid;
    logic [ADDR_W-1:0] hist_addr;

    function automatic logic [1:0] fwd_sel(
        input logic [ADDR_W-1:0] src,
        input logic [ADDR_W-1:0] mem_rd,
        input logic              mem_rw,
        input logic [ADDR_W-1:0] wb_rd,
        input logic              wb_rw,
        input logic              h_valid,
        input logic [ADDR_W-1:0] h_addr
    );
        logic [1:0] sel;
        sel = 2'b00;
        if (src != '0) begin
            if (mem_rw && (mem_rd == src)) begin
                sel = 2'b10;
            end else if (wb_rw && (wb_rd == src)) begin
                sel = 2'b01;
            end else if (h_valid && (h_addr == src)) begin
                sel = 2'b11;
            end
        end
        return sel;
    endfunction

    // Load in EX targets a register the instruction in ID reads; masked while in reset.
    always_comb begin
        load_use = 1'b0;
        if (rst_i && bus.ex_memread_i && (bus.ex_rd_addr_i != '0)) begin
            load_use = (bus.ex_rd_addr_i == bus.id_rs_addr_i) ||
                       (bus.ex_rd_addr_i == bus.id_rt_addr_i);
        end
    end

    // Multiplier FSM next state; the counter holds remaining BUSY cycles.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            StIdle: begin
                if (bus.ex_mul_i && !load_use) begin
                    state_d = StBusy;
                    cnt_d   = CNT_W'(MUL_LAT - 1);
                end
            end
            StBusy: begin
                if (cnt_q == CNT_W'(1)) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    // FSM state and counter registers.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Stall controls: a BUSY multiply freezes without a bubble since ID/EX must keep it.
    always_comb begin
        pc_write = 1'b1;
        bubble   = 1'b0;
        if (state_q == StBusy) begin
            pc_write = 1'b0;
        end else if (load_use) begin
            pc_write = 1'b0;
            bubble   = 1'b1;
        end
    end

`ifdef FWD_WB_HIST_EN
    logic              hist_valid_q, hist_valid_d;
    logic [ADDR_W-1:0] hist_addr_q, hist_addr_d;

    // History captures the retiring write unless the front end is frozen.
    always_comb begin
        hist_valid_d = hist_valid_q;
        hist_addr_d  = hist_addr_q;
        if (pc_write) begin
            hist_valid_d = bus.wb_regwrite_i && (bus.wb_rd_addr_i != '0);
            hist_addr_d  = bus.wb_rd_addr_i;
        end
    end

    // WB history register.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            hist_valid_q <= 1'b0;
            hist_addr_q  <= '0;
        end else begin
            hist_valid_q <= hist_valid_d;
            hist_addr_q  <= hist_addr_d;
        end
    end

    assign hist_valid = hist_valid_q;
    assign hist_addr  = hist_addr_q;
`else
    assign hist_valid = 1'b0;
    assign hist_addr  = '0;
`endif

    // Operand selects for both EX sources; EX/MEM beats MEM/WB beats history.
    always_comb begin
        sel1 = fwd_sel(bus.ex_rs_addr_i, bus.mem_rd_addr_i, bus.mem_regwrite_i,
                       bus.wb_rd_addr_i, bus.wb_regwrite_i, hist_valid, hist_addr);
        sel2 = fwd_sel(bus.ex_rt_addr_i, bus.mem_rd_addr_i, bus.mem_regwrite_i,
                       bus.wb_rd_addr_i, bus.wb_regwrite_i, hist_valid, hist_addr);
    end

    assign bus.select1_o     = rst_i ? sel1 : 2'b00;
    assign bus.select2_o     = rst_i ? sel2 : 2'b00;
    assign bus.pc_write_o    = pc_write;
    assign bus.if_id_write_o = pc_write;
    assign bus.bubble_o      = bubble;
    assign bus.mul_busy_o    = (state_q == StBusy);

endmodule

// File: tb/tb_forward_hazard_unit.sv
// Self-checking bench for forward_hazard_unit: directed scenarios plus a randomized
// run checked against a cycle-level model (stall cycles remaining, last WB write).
module tb_forward_hazard_unit;
    localparam int unsigned ADDR_W  = 5;
    localparam int unsigned MUL_LAT = 3;
    localparam int unsigned CNT_W   = 4;
`ifdef FWD_WB_HIST_EN
    localparam bit HistEn = 1'b1;
`else
    localparam bit HistEn = 1'b0;
`endif
    // {select1, select2, pc_write, if_id_write, bubble, mul_busy}
    localparam logic [7:0] Quiet = 8'b00_00_1_1_0_0;
    localparam logic [7:0] LuStall = 8'b00_00_0_0_1_0;
    localparam logic [7:0] MulStall = 8'b00_00_0_0_0_1;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    forward_hazard_unit_if #(.ADDR_W(ADDR_W)) bus_if ();

    forward_hazard_unit #(
        .ADDR_W (ADDR_W),
        .MUL_LAT(MUL_LAT),
        .CNT_W  (CNT_W)
    ) dut (
        .clk_i(clk),
        .rst_i(rst_n),
        .bus  (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] obs;
    assign obs = {bus_if.select1_o, bus_if.select2_o, bus_if.pc_write_o,
                  bus_if.if_id_write_o, bus_if.bubble_o, bus_if.mul_busy_o};

    // Reference model state
    int                m_busy_left = 0;
    logic              m_hist_valid = 1'b0;
    logic [ADDR_W-1:0] m_hist_addr = '0;

    function automatic logic m_load_use();
        return bus_if.ex_memread_i && (bus_if.ex_rd_addr_i != 0) &&
               ((bus_if.ex_rd_addr_i == bus_if.id_rs_addr_i) ||
                (bus_if.ex_rd_addr_i == bus_if.id_rt_addr_i));
    endfunction

    function automatic logic [1:0] m_sel(input logic [ADDR_W-1:0] a);
        if (a == 0) return 2'd0;
        if (bus_if.mem_regwrite_i && bus_if.mem_rd_addr_i == a) return 2'd2;
        if (bus_if.wb_regwrite_i && bus_if.wb_rd_addr_i == a) return 2'd1;
        if (HistEn && m_hist_valid && m_hist_addr == a) return 2'd3;
        return 2'd0;
    endfunction

    function automatic logic [7:0] m_out();
        logic busy;
        logic lu;
        if (!rst_n) return Quiet;
        busy = (m_busy_left > 0);
        lu   = m_load_use();
        return {m_sel(bus_if.ex_rs_addr_i), m_sel(bus_if.ex_rt_addr_i),
                !(busy || lu), !(busy || lu), lu && !busy, busy};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy_left  <= 0;
            m_hist_valid <= 1'b0;
            m_hist_addr  <= '0;
        end else begin
            if (m_busy_left > 0) m_busy_left <= m_busy_left - 1;
            else if (bus_if.ex_mul_i && !m_load_use()) m_busy_left <= MUL_LAT - 1;
            if (!((m_busy_left > 0) || m_load_use())) begin
                m_hist_valid <= bus_if.wb_regwrite_i && (bus_if.wb_rd_addr_i != 0);
                m_hist_addr  <= bus_if.wb_rd_addr_i;
            end
        end
    end

    task automatic clear_inputs();
        bus_if.id_rs_addr_i   = '0;
        bus_if.id_rt_addr_i   = '0;
        bus_if.ex_rs_addr_i   = '0;
        bus_if.ex_rt_addr_i   = '0;
        bus_if.ex_rd_addr_i   = '0;
        bus_if.ex_memread_i   = 1'b0;
        bus_if.ex_mul_i       = 1'b0;
        bus_if.mem_rd_addr_i  = '0;
        bus_if.mem_regwrite_i = 1'b0;
        bus_if.wb_rd_addr_i   = '0;
        bus_if.wb_regwrite_i  = 1'b0;
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic flush();
        clear_inputs();
        tick();
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus_if.ex_rs_addr_i   = 5'd5;
        bus_if.ex_rt_addr_i   = 5'd6;
        bus_if.mem_rd_addr_i  = 5'd5;
        bus_if.mem_regwrite_i = 1'b1;
        bus_if.wb_rd_addr_i   = 5'd6;
        bus_if.wb_regwrite_i  = 1'b1;
        bus_if.ex_memread_i   = 1'b1;
        bus_if.ex_rd_addr_i   = 5'd3;
        bus_if.id_rs_addr_i   = 5'd3;
        bus_if.ex_mul_i       = 1'b1;
        settle();
        checks++;
        if (obs !== Quiet) begin
            errors++;
            $display("FAIL reset_hold got %b want %b", obs, Quiet);
        end
        tick();
        checks++;
        if (obs !== Quiet) begin
            errors++;
            $display("FAIL reset_after_edge got %b want %b", obs, Quiet);
        end
        clear_inputs();
        tick();
        rst_n = 1'b1;
        tick();
        checks++;
        if (obs !== Quiet) begin
            errors++;
            $display("FAIL reset_release got %b want %b", obs, Quiet);
        end
    endtask

    task automatic test_forwarding();
        flush();
        bus_if.ex_rs_addr_i   = 5'd5;
        bus_if.mem_rd_addr_i  = 5'd5;
        bus_if.mem_regwrite_i = 1'b1;
        bus_if.wb_rd_addr_i   = 5'd5;
        bus_if.wb_regwrite_i  = 1'b1;
        settle();
        checks++;
        if (obs !== 8'b10_00_1_1_0_0) begin
            errors++;
            $display("FAIL fwd_exmem_priority got %b want %b", obs, 8'b10_00_1_1_0_0);
        end
        bus_if.mem_regwrite_i = 1'b0;
        settle();
        checks++;
        if (obs !== 8'b01_00_1_1_0_0) begin
            errors++;
            $display("FAIL fwd_memwb got %b want %b", obs, 8'b01_00_1_1_0_0);
        end
        bus_if.ex_rt_addr_i   = 5'd5;
        bus_if.mem_regwrite_i = 1'b1;
        bus_if.wb_rd_addr_i   = 5'd9;
        settle();
        checks++;
        if (obs !== 8'b10_10_1_1_0_0) begin
            errors++;
            $display("FAIL fwd_both_exmem got %b want %b", obs, 8'b10_10_1_1_0_0);
        end
        bus_if.ex_rs_addr_i   = 5'd9;
        bus_if.ex_rt_addr_i   = 5'd0;
        bus_if.mem_rd_addr_i  = 5'd0;
        bus_if.wb_rd_addr_i   = 5'd9;
        settle();
        checks++;
        if (obs !== 8'b01_00_1_1_0_0) begin
            errors++;
            $display("FAIL fwd_reg0_ignored got %b want %b", obs, 8'b01_00_1_1_0_0);
        end
    endtask

    task automatic test_load_use();
        flush();
        bus_if.ex_memread_i = 1'b1;
        bus_if.ex_rd_addr_i = 5'd7;
        bus_if.id_rt_addr_i = 5'd7;
        settle();
        checks++;
        if (obs !== LuStall) begin
            errors++;
            $display("FAIL load_use_rt got %b want %b", obs, LuStall);
        end
        tick();
        // Bubble now occupies ID/EX.
        bus_if.ex_memread_i = 1'b0;
        bus_if.ex_rd_addr_i = 5'd0;
        settle();
        checks++;
        if (obs !== Quiet) begin
            errors++;
            $display("FAIL load_use_one_cycle got %b want %b", obs, Quiet);
        end
        bus_if.ex_memread_i = 1'b1;
        bus_if.ex_rd_addr_i = 5'd12;
        bus_if.id_rs_addr_i = 5'd12;
        bus_if.id_rt_addr_i = 5'd0;
        settle();
        checks++;
        if (obs !== LuStall) begin
            errors++;
            $display("FAIL load_use_rs got %b want %b", obs, LuStall);
        end
        bus_if.ex_rd_addr_i = 5'd0;
        bus_if.id_rs_addr_i = 5'd0;
        settle();
        checks++;
        if (obs !== Quiet) begin
            errors++;
            $display("FAIL load_use_reg0 got %b want %b", obs, Quiet);
        end
    endtask

    task automatic test_mul();
        flush();
        bus_if.ex_mul_i = 1'b1;
        settle();
        checks++;
        if (obs !== Quiet) begin
            errors++;
            $display("FAIL mul_issue got %b want %b", obs, Quiet);
        end
        // ex_mul_i stays high while ID/EX holds the multiply.
        for (int c = 0; c < int'(MUL_LAT) - 1; c++) begin
            tick();
            bus_if.ex_rs_addr_i   = 5'd3;
            bus_if.mem_rd_addr_i  = 5'd3;
            bus_if.mem_regwrite_i = 1'b1;
            settle();
            checks++;
            if (obs !== 8'b10_00_0_0_0_1) begin
                errors++;
                $display("FAIL mul_busy_cycle%0d got %b want %b", c, obs, 8'b10_00_0_0_0_1);
            end
        end
        tick();
        clear_inputs();
        settle();
        checks++;
        if (obs !== Quiet) begin
            errors++;
            $display("FAIL mul_done got %b want %b", obs, Quiet);
        end
        bus_if.ex_mul_i = 1'b1;
        tick();
        bus_if.ex_mul_i = 1'b0;
        settle();
        checks++;
        if (obs !== MulStall) begin
            errors++;
            $display("FAIL mul_reenter got %b want %b", obs, MulStall);
        end
        rst_n = 1'b0;
        settle();
        checks++;
        if (obs !== Quiet) begin
            errors++;
            $display("FAIL mul_reset_abort got %b want %b", obs, Quiet);
        end
        tick();
        rst_n = 1'b1;
        tick();
        checks++;
        if (obs !== Quiet) begin
            errors++;
            $display("FAIL mul_after_reset got %b want %b", obs, Quiet);
        end
    endtask

    task automatic test_simultaneous();
        flush();
        bus_if.ex_memread_i = 1'b1;
        bus_if.ex_rd_addr_i = 5'd4;
        bus_if.id_rs_addr_i = 5'd4;
        bus_if.ex_mul_i     = 1'b1;
        settle();
        checks++;
        if (obs !== LuStall) begin
            errors++;
            $display("FAIL simul_bubble got %b want %b", obs, LuStall);
        end
        tick();
        bus_if.ex_memread_i = 1'b0;
        bus_if.ex_rd_addr_i = 5'd0;
        settle();
        checks++;
        if (obs !== Quiet) begin
            errors++;
            $display("FAIL simul_stays_idle got %b want %b", obs, Quiet);
        end
        tick();
        settle();
        checks++;
        if (obs !== MulStall) begin
            errors++;
            $display("FAIL simul_busy_entered got %b want %b", obs, MulStall);
        end
        tick();
        tick();
        bus_if.ex_mul_i = 1'b0;
        settle();
        checks++;
        if (obs !== Quiet) begin
            errors++;
            $display("FAIL simul_busy_exit got %b want %b", obs, Quiet);
        end
    endtask

    task automatic test_hist();
        logic [7:0] exp;
        flush();
        bus_if.wb_rd_addr_i  = 5'd9;
        bus_if.wb_regwrite_i = 1'b1;
        tick();
        bus_if.wb_rd_addr_i  = 5'd0;
        bus_if.wb_regwrite_i = 1'b0;
        bus_if.ex_rs_addr_i  = 5'd9;
        settle();
        exp = {(HistEn ? 2'b11 : 2'b00), 2'b00, 4'b1100};
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL hist_select got %b want %b", obs, exp);
        end
        flush();
        bus_if.wb_rd_addr_i  = 5'd11;
        bus_if.wb_regwrite_i = 1'b1;
        tick();
        // Stall cycle: the empty WB slot must not overwrite history.
        bus_if.wb_rd_addr_i  = 5'd0;
        bus_if.wb_regwrite_i = 1'b0;
        bus_if.ex_memread_i  = 1'b1;
        bus_if.ex_rd_addr_i  = 5'd2;
        bus_if.id_rs_addr_i  = 5'd2;
        tick();
        clear_inputs();
        bus_if.ex_rt_addr_i = 5'd11;
        settle();
        exp = {2'b00, (HistEn ? 2'b11 : 2'b00), 4'b1100};
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL hist_stall_hold got %b want %b", obs, exp);
        end
    endtask

    task automatic test_random();
        logic [7:0] exp;
        flush();
        for (int n = 0; n < 400; n++) begin
            rst_n = ($urandom_range(0, 59) != 0);
            bus_if.id_rs_addr_i   = ADDR_W'($urandom_range(0, 7));
            bus_if.id_rt_addr_i   = ADDR_W'($urandom_range(0, 7));
            bus_if.ex_rs_addr_i   = ADDR_W'($urandom_range(0, 7));
            bus_if.ex_rt_addr_i   = ADDR_W'($urandom_range(0, 7));
            bus_if.ex_rd_addr_i   = ADDR_W'($urandom_range(0, 7));
            bus_if.ex_memread_i   = ($urandom_range(0, 3) == 0);
            bus_if.ex_mul_i       = ($urandom_range(0, 5) == 0);
            bus_if.mem_rd_addr_i  = ADDR_W'($urandom_range(0, 7));
            bus_if.mem_regwrite_i = $urandom_range(0, 1) == 1;
            bus_if.wb_rd_addr_i   = ADDR_W'($urandom_range(0, 7));
            bus_if.wb_regwrite_i  = $urandom_range(0, 1) == 1;
            settle();
            exp = m_out();
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL random_cycle%0d got %b want %b", n, obs, exp);
            end
            tick();
        end
        rst_n = 1'b1;
        clear_inputs();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        clear_inputs();
        #2;
        test_reset();
        test_forwarding();
        test_load_use();
        test_mul();
        test_simultaneous();
        test_hist();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
